// File: rtl/vga_display_bus_frontend_pkg.sv
// Shared types and constants for the display bus front-end: FSM states,
// register map, STATUS layout and the pixel FIFO entry format.
package display_frontend_pkg;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_DRAIN,
        ST_FILL,
        ST_DONE
    } fe_state_t;

    // Register map (byte addresses). Every read returns STATUS, so
    // ADDR_STATUS is only the address software is expected to use.
    localparam logic [31:0] ADDR_CLEAR       = 32'h0000_0000;
    localparam logic [31:0] ADDR_STATUS      = 32'h0000_0004;
    localparam logic [31:0] ADDR_IRQEN       = 32'h0000_0008;
    localparam logic [31:0] ADDR_BITMAP_BASE = 32'h0000_0100;

    // STATUS register bit positions
    localparam int STAT_BUSY_BIT     = 0;
    localparam int STAT_IRQ_PEND_BIT = 1;
    localparam int STAT_IRQ_EN_BIT   = 2;
    localparam int STAT_FIFO_CNT_LSB = 8;

    // One buffered pixel write: pixel index and already-masked colour
    typedef struct packed {
        logic [31:0] addr;
        logic [31:0] data;
    } fifo_entry_t;

    // Mask keeping the low w colour bits of a 32-bit bus word
    function automatic logic [31:0] color_mask(input int w);
        if (w >= 32) begin
            return '1;
        end
        return (32'd1 << w) - 32'd1;
    endfunction

endpackage

// File: rtl/vga_display_bus_frontend_if.sv
// Bus bundle of the display front-end: device bus, read response, IRQ and
// the display-controller write port. The slave side is the front-end.
interface vga_display_bus_frontend_if;

    logic        iDEV_REQ;
    logic        oDEV_BUSY;
    logic        iDEV_RW;
    logic [31:0] iDEV_ADDR;
    logic [31:0] iDEV_DATA;
    logic        oDEV_REQ;
    logic        iDEV_BUSY;
    logic [31:0] oDEV_DATA;
    logic        oDEV_IRQ_REQ;
    logic        iDEV_IRQ_BUSY;
    logic        iDEV_IRQ_ACK;
    logic        oDISP_WR_REQ;
    logic        iDISP_WR_BUSY;
    logic [31:0] oDISP_WR_ADDR;
    logic [31:0] oDISP_WR_DATA;

    modport slave (
        input  iDEV_REQ, iDEV_RW, iDEV_ADDR, iDEV_DATA, iDEV_BUSY,
        input  iDEV_IRQ_BUSY, iDEV_IRQ_ACK, iDISP_WR_BUSY,
        output oDEV_BUSY, oDEV_REQ, oDEV_DATA, oDEV_IRQ_REQ,
        output oDISP_WR_REQ, oDISP_WR_ADDR, oDISP_WR_DATA
    );

    modport master (
        output iDEV_REQ, iDEV_RW, iDEV_ADDR, iDEV_DATA, iDEV_BUSY,
        output iDEV_IRQ_BUSY, iDEV_IRQ_ACK, iDISP_WR_BUSY,
        input  oDEV_BUSY, oDEV_REQ, oDEV_DATA, oDEV_IRQ_REQ,
        input  oDISP_WR_REQ, oDISP_WR_ADDR, oDISP_WR_DATA
    );

endinterface

// File: rtl/vga_display_bus_frontend_wr_fifo.sv
// Synchronous FIFO buffering pixel writes toward the display controller.
// Show-ahead: rdata_o is the head entry whenever empty_o is low.
module display_wr_fifo #(
    parameter int DEPTH = 16,   // power of 2, >= 2
    parameter int WIDTH = 64
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     clr_i,
    input  logic                     push_i,
    input  logic [WIDTH-1:0]         wdata_i,
    input  logic                     pop_i,
    output logic [WIDTH-1:0]         rdata_o,
    output logic                     full_o,
    output logic                     empty_o,
    output logic [$clog2(DEPTH):0]   count_o
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [PTR_W-1:0] wr_ptr_q, rd_ptr_q;
    logic [CNT_W-1:0] count_q;
    logic             do_push, do_pop;

    assign full_o  = (count_q == CNT_W'(DEPTH));
    assign empty_o = (count_q == '0);
    assign count_o = count_q;
    assign rdata_o = mem_q[rd_ptr_q];

    assign do_push = push_i && !full_o;
    assign do_pop  = pop_i && !empty_o;

    // Pointer and occupancy bookkeeping; pointers wrap naturally at DEPTH
    // NOTE: sequential state uses <= so every flop samples pre-edge values.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else if (clr_i) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (do_push) wr_ptr_q <= wr_ptr_q + 1'b1;
            if (do_pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
            unique case ({do_push, do_pop})
                2'b10:   count_q <= count_q + 1'b1;
                2'b01:   count_q <= count_q - 1'b1;
                default: count_q <= count_q;
            endcase
        end
    end

    // Storage array write port
    // NOTE: the array has no reset; its contents are meaningless until the
    // count says an entry is valid, and a resettable array costs real flops.
    always_ff @(posedge clk) begin
        if (do_push) mem_q[wr_ptr_q] <= wdata_i;
    end

endmodule

// File: rtl/vga_display_bus_frontend.sv
// Bus-side front-end of the display device: decodes bus commands, buffers
// pixel writes in a FIFO, runs the hardware clear/fill engine, serves the
// STATUS read and raises a level IRQ when a clear completes.
module vga_display_bus_frontend
    import display_frontend_pkg::*;
#(
    parameter int H_RES      = 640,
    parameter int V_RES      = 480,
    parameter int FIFO_DEPTH = 16,
    parameter int COLOR_W    = 12
) (
    input  logic                         iCLOCK,
    input  logic                         inRESET,
    input  logic                         iRESET_SYNC,
    vga_display_bus_frontend_if.slave    bus
);

    localparam int unsigned PIX_COUNT = H_RES * V_RES;
    localparam int          CNT_W     = (PIX_COUNT > 1) ? $clog2(PIX_COUNT) : 1;
    localparam logic [CNT_W-1:0] PIX_LAST = CNT_W'(PIX_COUNT - 1);
    localparam int          FCNT_W    = $clog2(FIFO_DEPTH) + 1;
    localparam logic [31:0] COLOR_MSK = color_mask(COLOR_W);

    fe_state_t         state_q, state_d;
    logic [CNT_W-1:0]  fill_cnt_q, fill_cnt_d;
    logic [31:0]       color_q, color_d;
    logic              irq_en_q, irq_pend_q, set_irq;
    logic              rsp_valid_q;
    logic [31:0]       rsp_data_q;

    fifo_entry_t       push_entry, head;
    logic              fifo_push, fifo_pop, fifo_full, fifo_empty;
    logic [FCNT_W-1:0] fifo_count;

    logic              live, dev_busy, accept, wr_acc, rd_acc;
    logic              clear_acc, irqen_acc, pix_hit;
    logic [31:0]       pix_idx, color_in, status;
    logic              disp_req, disp_xfer;
    logic [31:0]       disp_addr, disp_data;

    // ---------------- bus decode ----------------
    assign live      = !iRESET_SYNC;
    assign dev_busy  = fifo_full || (state_q != ST_IDLE) || rsp_valid_q;
    assign accept    = live && bus.iDEV_REQ && !dev_busy;
    assign wr_acc    = accept && bus.iDEV_RW;
    assign rd_acc    = accept && !bus.iDEV_RW;
    assign clear_acc = wr_acc && (bus.iDEV_ADDR == ADDR_CLEAR);
    assign irqen_acc = wr_acc && (bus.iDEV_ADDR == ADDR_IRQEN);
    assign pix_idx   = (bus.iDEV_ADDR - ADDR_BITMAP_BASE) >> 2;
    assign pix_hit   = wr_acc && (bus.iDEV_ADDR >= ADDR_BITMAP_BASE)
                       && (pix_idx < PIX_COUNT);
    assign color_in  = bus.iDEV_DATA & COLOR_MSK;

    assign push_entry = '{addr: pix_idx, data: color_in};
    assign fifo_push  = pix_hit;

    display_wr_fifo #(
        .DEPTH (FIFO_DEPTH),
        .WIDTH ($bits(fifo_entry_t))
    ) u_fifo (
        .clk     (iCLOCK),
        .rst_n   (inRESET),
        .clr_i   (iRESET_SYNC),
        .push_i  (fifo_push),
        .wdata_i (push_entry),
        .pop_i   (fifo_pop),
        .rdata_o (head),
        .full_o  (fifo_full),
        .empty_o (fifo_empty),
        .count_o (fifo_count)
    );

    // STATUS word as seen by a read accepted this cycle
    // NOTE: every always_comb output gets a default first so no path infers a latch.
    always_comb begin
        status = '0;
        status[STAT_FIFO_CNT_LSB +: 8] = 8'(fifo_count);
        status[STAT_IRQ_EN_BIT]        = irq_en_q;
        status[STAT_IRQ_PEND_BIT]      = irq_pend_q;
        status[STAT_BUSY_BIT]          = (state_q != ST_IDLE);
    end

    // ---------------- clear/fill FSM ----------------
    assign disp_xfer = disp_req && !bus.iDISP_WR_BUSY;

    // FSM state, fill counter and latched clear colour
    always_ff @(posedge iCLOCK or negedge inRESET) begin
        if (!inRESET) begin
            state_q    <= ST_IDLE;
            fill_cnt_q <= '0;
            color_q    <= '0;
        end else begin
            state_q    <= state_d;
            fill_cnt_q <= fill_cnt_d;
            color_q    <= color_d;
        end
    end

    // Next state and display-port drive; FIFO pixels always precede a fill
    always_comb begin
        state_d    = state_q;
        fill_cnt_d = fill_cnt_q;
        color_d    = color_q;
        disp_req   = 1'b0;
        disp_addr  = '0;
        disp_data  = '0;
        fifo_pop   = 1'b0;
        set_irq    = 1'b0;
        unique case (state_q)
            ST_IDLE, ST_DRAIN: begin
                // Head is only presented when valid so stale RAM never leaks out
                disp_req  = !fifo_empty;
                disp_addr = fifo_empty ? '0 : head.addr;
                disp_data = fifo_empty ? '0 : head.data;
                fifo_pop  = disp_xfer;
                if (state_q == ST_IDLE) begin
                    if (clear_acc) begin
                        state_d = ST_DRAIN;
                        color_d = color_in;
                    end
                end else if (fifo_empty) begin
                    state_d    = ST_FILL;
                    fill_cnt_d = '0;
                end
            end
            ST_FILL: begin
                disp_req  = 1'b1;
                disp_addr = 32'(fill_cnt_q);
                disp_data = color_q;
                if (disp_xfer) begin
                    if (fill_cnt_q == PIX_LAST) state_d = ST_DONE;
                    else fill_cnt_d = fill_cnt_q + 1'b1;
                end
            end
            ST_DONE: begin
                set_irq = irq_en_q;
                state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
        // Soft reset aborts whatever is in flight
        if (iRESET_SYNC) begin
            state_d    = ST_IDLE;
            fill_cnt_d = '0;
            color_d    = '0;
            disp_req   = 1'b0;
            disp_addr  = '0;
            disp_data  = '0;
            fifo_pop   = 1'b0;
            set_irq    = 1'b0;
        end
    end

    // ---------------- IRQ and read response ----------------
    // IRQ enable/pending flags and the registered read response
    always_ff @(posedge iCLOCK or negedge inRESET) begin
        if (!inRESET) begin
            irq_en_q    <= 1'b0;
            irq_pend_q  <= 1'b0;
            rsp_valid_q <= 1'b0;
            rsp_data_q  <= '0;
        end else if (iRESET_SYNC) begin
            irq_en_q    <= 1'b0;
            irq_pend_q  <= 1'b0;
            rsp_valid_q <= 1'b0;
            rsp_data_q  <= '0;
        end else begin
            if (irqen_acc) irq_en_q <= bus.iDEV_DATA[0];
            // Completion beats a same-cycle acknowledge
            if (set_irq)               irq_pend_q <= 1'b1;
            else if (bus.iDEV_IRQ_ACK) irq_pend_q <= 1'b0;
            if (rd_acc) begin
                rsp_valid_q <= 1'b1;
                rsp_data_q  <= status;
            end else if (rsp_valid_q && !bus.iDEV_BUSY) begin
                rsp_valid_q <= 1'b0;
                rsp_data_q  <= '0;
            end
        end
    end

    // ---------------- outputs (forced low during soft reset) ----------------
    assign bus.oDEV_BUSY     = live && dev_busy;
    assign bus.oDEV_REQ      = live && rsp_valid_q;
    assign bus.oDEV_DATA     = live ? rsp_data_q : '0;
    assign bus.oDEV_IRQ_REQ  = live && irq_pend_q && !bus.iDEV_IRQ_BUSY;
    assign bus.oDISP_WR_REQ  = disp_req;
    assign bus.oDISP_WR_ADDR = disp_addr;
    assign bus.oDISP_WR_DATA = disp_data;

endmodule

// File: tb/tb_vga_display_bus_frontend.sv
// Self-checking bench for vga_display_bus_frontend, built with a small
// 4x2 frame so clear/fill sequences stay short.
module tb_vga_display_bus_frontend;

    localparam int H     = 4;
    localparam int V     = 2;
    localparam int DEPTH = 16;
    localparam int CW    = 12;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic rst_sync = 1'b0;
    int   cyc = 0;
    int   n_cmp = 0;
    int   n_bad = 0;
    int   irq_cyc = -1;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    vga_display_bus_frontend_if bus ();

    vga_display_bus_frontend #(
        .H_RES(H), .V_RES(V), .FIFO_DEPTH(DEPTH), .COLOR_W(CW)
    ) dut (
        .iCLOCK      (clk),
        .inRESET     (rst_n),
        .iRESET_SYNC (rst_sync),
        .bus         (bus)
    );

    typedef struct {
        logic [31:0] addr;
        logic [31:0] data;
        int          cyc;
    } xfer_t;

    typedef struct {
        logic [31:0] addr;
        logic [31:0] data;
        bit          hit;
        logic [31:0] exp_addr;
        logic [31:0] exp_data;
    } vec_t;

    xfer_t xq[$];
    xfer_t eq[$];
    vec_t  vecs[8];

    // Record every completed display transfer
    always @(negedge clk) begin : mon
        xfer_t t;
        if (bus.oDISP_WR_REQ && !bus.iDISP_WR_BUSY) begin
            t.addr = bus.oDISP_WR_ADDR;
            t.data = bus.oDISP_WR_DATA;
            t.cyc  = cyc;
            xq.push_back(t);
        end
    end

    // First cycle the IRQ line is seen high
    always @(negedge clk) begin
        if (bus.oDEV_IRQ_REQ && irq_cyc < 0) irq_cyc = cyc;
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
        end
    endtask

    task automatic timeout_fail(input string name);
        n_cmp++;
        n_bad++;
        $display("FAIL %s: got timeout expected event", name);
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic sample();
        @(negedge clk);
    endtask

    function automatic xfer_t mk(input logic [31:0] a, input logic [31:0] d);
        xfer_t t;
        t.addr = a;
        t.data = d;
        t.cyc  = 0;
        return t;
    endfunction

    // Hold the already-driven request until accepted; count busy cycles seen
    task automatic wait_accept(input string name, output int nbusy);
        bit ok = 1'b0;
        nbusy = 0;
        for (int i = 0; i < 200; i++) begin
            sample();
            ok = !bus.oDEV_BUSY;
            step();
            if (ok) break;
            nbusy++;
        end
        bus.iDEV_REQ = 1'b0;
        if (!ok) timeout_fail(name);
    endtask

    task automatic bus_write(input logic [31:0] a, input logic [31:0] d);
        int nb;
        bus.iDEV_REQ  = 1'b1;
        bus.iDEV_RW   = 1'b1;
        bus.iDEV_ADDR = a;
        bus.iDEV_DATA = d;
        wait_accept("write_accept", nb);
    endtask

    task automatic bus_read(input int busy_cycles, output logic [31:0] data,
                            output int nbusy, output int nreq);
        bus.iDEV_REQ  = 1'b1;
        bus.iDEV_RW   = 1'b0;
        bus.iDEV_ADDR = 32'h0000_0004;
        bus.iDEV_DATA = '0;
        wait_accept("read_accept", nbusy);
        data = '0;
        nreq = 0;
        for (int i = 0; i < 20; i++) begin
            bus.iDEV_BUSY = (i < busy_cycles);
            sample();
            if (!bus.oDEV_REQ) break;
            nreq++;
            data = bus.oDEV_DATA;
            step();
        end
        bus.iDEV_BUSY = 1'b0;
        step();
    endtask

    task automatic wait_xfers(input string name, input int n);
        int i = 0;
        while (xq.size() < n && i < 200) begin
            step();
            i++;
        end
        if (xq.size() < n) timeout_fail(name);
    endtask

    task automatic check_xfers(input string name);
        check({name, "_count"}, xq.size(), eq.size());
        for (int i = 0; i < eq.size() && i < xq.size(); i++) begin
            check($sformatf("%s_addr%0d", name, i), xq[i].addr, eq[i].addr);
            check($sformatf("%s_data%0d", name, i), xq[i].data, eq[i].data);
        end
        xq.delete();
        eq.delete();
    endtask

    initial begin : main
        logic [31:0] rd;
        int          nb, nr;

        vecs[0] = '{32'h0000_0100, 32'h0000_0F00, 1'b1, 32'd0, 32'h0000_0F00};
        vecs[1] = '{32'h0000_0104, 32'h0000_00F0, 1'b1, 32'd1, 32'h0000_00F0};
        vecs[2] = '{32'h0000_011C, 32'hABCD_E123, 1'b1, 32'd7, 32'h0000_0123};
        vecs[3] = '{32'h0000_0120, 32'h0000_0555, 1'b0, 32'd0, 32'h0};
        vecs[4] = '{32'h0000_0004, 32'h0000_0777, 1'b0, 32'd0, 32'h0};
        vecs[5] = '{32'h0000_0110, 32'hFFFF_FFFF, 1'b1, 32'd4, 32'h0000_0FFF};
        vecs[6] = '{32'hFFFF_FF00, 32'h0000_0001, 1'b0, 32'd0, 32'h0};
        vecs[7] = '{32'h0000_00FC, 32'h0000_0003, 1'b0, 32'd0, 32'h0};

        bus.iDEV_REQ      = 1'b0;
        bus.iDEV_RW       = 1'b0;
        bus.iDEV_ADDR     = '0;
        bus.iDEV_DATA     = '0;
        bus.iDEV_BUSY     = 1'b0;
        bus.iDEV_IRQ_BUSY = 1'b0;
        bus.iDEV_IRQ_ACK  = 1'b0;
        bus.iDISP_WR_BUSY = 1'b0;

        // ---- reset state ----
        repeat (3) @(posedge clk);
        #1 rst_n = 1'b1;
        sample();
        check("rst_dev_busy",  bus.oDEV_BUSY,     0);
        check("rst_dev_req",   bus.oDEV_REQ,      0);
        check("rst_dev_data",  bus.oDEV_DATA,     0);
        check("rst_irq",       bus.oDEV_IRQ_REQ,  0);
        check("rst_disp_req",  bus.oDISP_WR_REQ,  0);
        check("rst_disp_addr", bus.oDISP_WR_ADDR, 0);
        check("rst_disp_data", bus.oDISP_WR_DATA, 0);
        step();
        bus_read(0, rd, nb, nr);
        check("rst_status", rd, 32'h0);

        // ---- single-write vector table ----
        for (int i = 0; i < 8; i++) begin
            xq.delete();
            bus_write(vecs[i].addr, vecs[i].data);
            repeat (3) step();
            check($sformatf("vec%0d_xfers", i), xq.size(), vecs[i].hit ? 1 : 0);
            if (vecs[i].hit && xq.size() > 0) begin
                check($sformatf("vec%0d_addr", i), xq[0].addr, vecs[i].exp_addr);
                check($sformatf("vec%0d_data", i), xq[0].data, vecs[i].exp_data);
            end
        end
        xq.delete();
        bus_read(0, rd, nb, nr);
        check("vec_status_empty", rd, 32'h0);

        // ---- FIFO fill to full with the display stalled ----
        bus.iDISP_WR_BUSY = 1'b1;
        for (int i = 0; i < DEPTH; i++) begin
            bus_write(32'h100 + 32'(4 * (i % 8)), 32'h100 + 32'(i));
            eq.push_back(mk(32'(i % 8), 32'h100 + 32'(i)));
        end
        sample();
        check("full_busy", bus.oDEV_BUSY, 1);
        step();
        bus.iDEV_REQ  = 1'b1;
        bus.iDEV_RW   = 1'b1;
        bus.iDEV_ADDR = 32'h100;
        bus.iDEV_DATA = 32'h110;
        repeat (3) begin
            sample();
            check("full_hold_busy", bus.oDEV_BUSY, 1);
            step();
        end
        check("full_no_xfer", xq.size(), 0);
        bus.iDISP_WR_BUSY = 1'b0;
        wait_accept("full_17th_accept", nb);
        check("full_17th_waited", (nb >= 1) ? 1 : 0, 1);
        eq.push_back(mk(32'd0, 32'h110));
        wait_xfers("full_drain", DEPTH + 1);
        check_xfers("full");

        // ---- clear with queued pixels, IRQ, read stalled behind the fill ----
        bus.iDISP_WR_BUSY = 1'b1;
        bus_write(32'h008, 32'h1);
        bus_write(32'h114, 32'hA);
        bus_write(32'h118, 32'hB);
        bus_write(32'h11C, 32'hC);
        bus_write(32'h000, 32'h0000_F00F);
        bus.iDISP_WR_BUSY = 1'b0;
        irq_cyc = -1;
        bus_read(3, rd, nb, nr);
        check("fill_busy_cycles", nb, 13);
        check("fill_rd_hold", nr, 4);
        check("fill_rd_status", rd, 32'h6);
        eq.push_back(mk(32'd5, 32'hA));
        eq.push_back(mk(32'd6, 32'hB));
        eq.push_back(mk(32'd7, 32'hC));
        for (int p = 0; p < H * V; p++) eq.push_back(mk(32'(p), 32'h00F));
        if (xq.size() > 0)
            check("irq_delay", irq_cyc - xq[xq.size() - 1].cyc, 2);
        else
            timeout_fail("irq_delay");
        check_xfers("clear");

        sample();
        check("irq_level", bus.oDEV_IRQ_REQ, 1);
        step();
        bus_write(32'h008, 32'h0);
        sample();
        check("irq_kept_en0", bus.oDEV_IRQ_REQ, 1);
        step();
        bus.iDEV_IRQ_BUSY = 1'b1;
        sample();
        check("irq_masked_busy", bus.oDEV_IRQ_REQ, 0);
        step();
        bus.iDEV_IRQ_BUSY = 1'b0;
        bus.iDEV_IRQ_ACK  = 1'b1;
        step();
        bus.iDEV_IRQ_ACK  = 1'b0;
        sample();
        check("irq_acked", bus.oDEV_IRQ_REQ, 0);
        step();
        bus_read(0, rd, nb, nr);
        check("irq_status_after_ack", rd, 32'h0);

        // ---- soft reset in the middle of a fill ----
        bus_write(32'h008, 32'h1);
        bus_write(32'h000, 32'h123);
        repeat (5) step();
        sample();
        check("srst_fill_active", bus.oDISP_WR_REQ, 1);
        step();
        rst_sync = 1'b1;
        sample();
        check("srst_in_busy", bus.oDEV_BUSY, 0);
        check("srst_in_req",  bus.oDISP_WR_REQ, 0);
        step();
        rst_sync = 1'b0;
        xq.delete();
        sample();
        check("srst_after_req",  bus.oDISP_WR_REQ, 0);
        check("srst_after_busy", bus.oDEV_BUSY, 0);
        repeat (5) step();
        check("srst_no_xfers", xq.size(), 0);
        bus_read(0, rd, nb, nr);
        check("srst_status", rd, 32'h0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got no end of test, expected finish");
        $fatal(1);
    end

endmodule
